// File: rtl/screen_fetch.sv
// Character-mode screen fetcher: reads attribute and font bytes over the shared bus and writes pixel nibbles to VRAM.
// Optional flashing attribute support is enabled with `define SCREEN_FLASH_EN.
module screen_fetch #(
  parameter int unsigned COLS      = 108,
  parameter int unsigned LINES     = 64,
  parameter int unsigned VRAM_AW   = 14,
  parameter int unsigned FLASH_DIV = 16
) (
  input  logic               mck,
  input  logic               rin,
  input  logic               lcdon,
  input  logic [1:0]         clkcnt,
  input  logic [7:0]         cdi,
  input  logic [12:0]        pb0,
  input  logic [9:0]         pb1,
  input  logic [8:0]         pb2,
  input  logic [10:0]        pb3,
  input  logic [10:0]        sbr,
  output logic [21:0]        va,
  output logic [VRAM_AW-1:0] vram_a,
  output logic [3:0]         vram_do,
  output logic               vram_gry,
  output logic               vram_we,
  output logic               frame_done
);

  localparam int unsigned CW      = ($clog2(COLS) > 7) ? $clog2(COLS) : 7;
  localparam int unsigned LW      = ($clog2(LINES) > 6) ? $clog2(LINES) : 6;
  localparam int unsigned NIBBLES = LINES * COLS * 2;

  typedef enum logic [2:0] {
    ATTR_ADR, ATTR_LO, ATTR_HI, PIX_ADR, PIX_RD, PIX_WR
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [LW-1:0]      line_q, line_d;
  logic [VRAM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [13:0]        sba_q, sba_d;
  logic [7:0]         p_q, p_d;
  logic [21:0]        va_q, va_d;
  logic [VRAM_AW-1:0] vram_a_q, vram_a_d;
  logic [3:0]         vram_do_q, vram_do_d;
  logic               vram_gry_q, vram_gry_d;
  logic               vram_we_q, vram_we_d;
  logic               frame_done_q, frame_done_d;
  logic               pend_lo_q, pend_lo_d;
  logic               flash_blank;
  logic [7:0]         pix;
  logic [21:0]        pix_va;

`ifdef SCREEN_FLASH_EN
  localparam int unsigned FW = $clog2(FLASH_DIV + 1);
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fph_q, fph_d;

  always_comb begin
    fcnt_d = fcnt_q;
    fph_d  = fph_q;
    if (frame_done_q) begin
      if (fcnt_q == FW'(FLASH_DIV - 1)) begin
        fcnt_d = '0;
        fph_d  = ~fph_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      fcnt_q <= '0;
      fph_q  <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      fph_q  <= fph_d;
    end
  end

  assign flash_blank = fph_q & sba_q[11];
`else
  logic unused_flash_attr;
  assign unused_flash_attr = sba_q[11];
  assign flash_blank       = 1'b0;
`endif

  // Null wins outright; underline is applied before reverse so reverse+underline yields a blank row.
  always_comb begin
    pix = cdi;
    if (sba_q[13:12] == 2'b11) begin
      pix = '0;
    end else begin
      if (!sba_q[13] && sba_q[9] && (line_q[2:0] == 3'd7)) pix = '1;
      if (sba_q[12]) pix = ~pix;
    end
    if (flash_blank) pix = '0;
  end

  always_comb begin
    if (!sba_q[13]) begin
      if (sba_q[8:6] == 3'b111) pix_va = {pb0, sba_q[5:0], line_q[2:0]};
      else                      pix_va = {pb1, sba_q[8:0], line_q[2:0]};
    end else begin
      if (sba_q[9:8] == 2'b11)  pix_va = {pb3, sba_q[7:0], line_q[2:0]};
      else                      pix_va = {pb2, sba_q[9:0], line_q[2:0]};
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    wr_addr_d    = wr_addr_q;
    sba_d        = sba_q;
    p_d          = p_q;
    va_d         = va_q;
    vram_a_d     = vram_a_q;
    vram_do_d    = vram_do_q;
    vram_gry_d   = vram_gry_q;
    vram_we_d    = 1'b0;
    pend_lo_d    = pend_lo_q;
    frame_done_d = vram_we_q && (vram_a_q == VRAM_AW'(NIBBLES - 1));
    if (!lcdon) begin
      state_d      = ATTR_ADR;
      col_d        = '0;
      line_d       = '0;
      wr_addr_d    = '0;
      pend_lo_d    = 1'b0;
      frame_done_d = 1'b0;
    end else begin
      case (state_q)
        // The low nibble of the previous character shares this slot with the next attribute address.
        ATTR_ADR: if (clkcnt == 2'b10) begin
          va_d = {sbr, line_q[5:3], col_q[6:0], 1'b0};
          if (pend_lo_q) begin
            vram_we_d = 1'b1;
            vram_a_d  = {vram_a_q[VRAM_AW-1:1], 1'b1};
            vram_do_d = p_q[3:0];
            pend_lo_d = 1'b0;
          end
          state_d = ATTR_LO;
        end
        ATTR_LO: if (clkcnt == 2'b00) begin
          sba_d[7:0] = cdi;
          va_d[0]    = 1'b1;
          state_d    = ATTR_HI;
        end
        ATTR_HI: if (clkcnt == 2'b01) begin
          sba_d[13:8] = cdi[5:0];
          state_d     = PIX_ADR;
        end
        PIX_ADR: if (clkcnt == 2'b10) begin
          va_d    = pix_va;
          state_d = PIX_RD;
        end
        PIX_RD: if (clkcnt == 2'b00) begin
          p_d     = pix;
          state_d = PIX_WR;
        end
        PIX_WR: if (clkcnt == 2'b01) begin
          vram_we_d  = 1'b1;
          vram_a_d   = wr_addr_q;
          vram_do_d  = p_q[7:4];
          vram_gry_d = sba_q[10];
          pend_lo_d  = 1'b1;
          state_d    = ATTR_ADR;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            if (line_q == LW'(LINES - 1)) begin
              line_d    = '0;
              wr_addr_d = '0;
            end else begin
              line_d    = line_q + 1'b1;
              wr_addr_d = wr_addr_q + VRAM_AW'(2);
            end
          end else begin
            col_d     = col_q + 1'b1;
            wr_addr_d = wr_addr_q + VRAM_AW'(2);
          end
        end
        default: state_d = ATTR_ADR;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      state_q      <= ATTR_ADR;
      col_q        <= '0;
      line_q       <= '0;
      wr_addr_q    <= '0;
      sba_q        <= '0;
      p_q          <= '0;
      va_q         <= '0;
      vram_a_q     <= '0;
      vram_do_q    <= '0;
      vram_gry_q   <= 1'b0;
      vram_we_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pend_lo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      wr_addr_q    <= wr_addr_d;
      sba_q        <= sba_d;
      p_q          <= p_d;
      va_q         <= va_d;
      vram_a_q     <= vram_a_d;
      vram_do_q    <= vram_do_d;
      vram_gry_q   <= vram_gry_d;
      vram_we_q    <= vram_we_d;
      frame_done_q <= frame_done_d;
      pend_lo_q    <= pend_lo_d;
    end
  end

  assign va         = va_q;
  assign vram_a     = vram_a_q;
  assign vram_do    = vram_do_q;
  assign vram_gry   = vram_gry_q;
  assign vram_we    = vram_we_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_screen_fetch.sv
// Randomized bench for screen_fetch against a character-level reference model (COLS=4, LINES=8, FLASH_DIV=2).
module tb_screen_fetch;

  localparam int COLS = 4;
  localparam int LINES = 8;
  localparam int AW = 6;
  localparam int FDIV = 2;
  localparam int NIB = COLS * LINES * 2;

  logic          mck = 1'b0;
  logic          rin, lcdon;
  logic [1:0]    clkcnt;
  logic [7:0]    cdi;
  logic [12:0]   pb0;
  logic [9:0]    pb1;
  logic [8:0]    pb2;
  logic [10:0]   pb3;
  logic [10:0]   sbr;
  logic [21:0]   va;
  logic [AW-1:0] vram_a;
  logic [3:0]    vram_do;
  logic          vram_gry, vram_we, frame_done;

  screen_fetch #(.COLS(COLS), .LINES(LINES), .VRAM_AW(AW), .FLASH_DIV(FDIV)) dut (
    .mck(mck), .rin(rin), .lcdon(lcdon), .clkcnt(clkcnt), .cdi(cdi),
    .pb0(pb0), .pb1(pb1), .pb2(pb2), .pb3(pb3), .sbr(sbr),
    .va(va), .vram_a(vram_a), .vram_do(vram_do), .vram_gry(vram_gry),
    .vram_we(vram_we), .frame_done(frame_done)
  );

  always #5 mck = ~mck;

  int          n_tests = 0;
  int          n_fail = 0;
  int          m_col, m_line, frames_done, pend_addr, chars_run;
  bit          pend, fd_due;
  logic [3:0]  pend_nib;
  logic        pend_gry;
  logic [21:0] m_va;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] attr_addr(input int col, input int line);
    return 22'((int'(sbr) << 11) | (((line >> 3) & 7) << 8) | ((col & 127) << 1));
  endfunction

  function automatic logic [21:0] pix_addr(input logic [13:0] a, input int line);
    logic [2:0] ln;
    ln = 3'(line);
    if (!a[13]) begin
      if (a[8:6] == 3'b111) return {pb0, a[5:0], ln};
      return {pb1, a[8:0], ln};
    end
    if (a[9:8] == 2'b11) return {pb3, a[7:0], ln};
    return {pb2, a[9:0], ln};
  endfunction

  function automatic logic [7:0] pix_val(input logic [13:0] a, input int line, input logic [7:0] raw);
    logic [7:0] p;
    p = raw;
    if (a[13:12] == 2'b11) p = 8'h00;
    else begin
      if (!a[13] && a[9] && (line % 8 == 7)) p = 8'hFF;
      if (a[12]) p = ~p;
    end
`ifdef SCREEN_FLASH_EN
    if (a[11] && ((frames_done / FDIV) % 2 == 1)) p = 8'h00;
`endif
    return p;
  endfunction

  task automatic step(input logic [1:0] cc, input logic [7:0] d, input bit we_e,
                      input int a_e, input logic [3:0] do_e, input logic gry_e);
    clkcnt = cc;
    cdi    = d;
    @(posedge mck);
    #1;
    check("va", va, m_va);
    check("vram_we", vram_we, we_e);
    if (we_e) begin
      check("vram_a", vram_a, a_e);
      check("vram_do", vram_do, do_e);
      check("vram_gry", vram_gry, gry_e);
    end
    check("frame_done", frame_done, fd_due);
    fd_due = we_e && (a_e == NIB - 1);
    if (fd_due) frames_done++;
  endtask

  task automatic run_char(input logic [13:0] attr, input logic [7:0] raw, input bit rst_at_wr);
    int         base;
    logic [7:0] p;
    base = (m_line * COLS + m_col) * 2;
    m_va = attr_addr(m_col, m_line);
    step(2'b10, 8'($urandom), pend, pend_addr, pend_nib, pend_gry);
    pend = 0;
    step(2'b11, 8'($urandom), 0, 0, 4'h0, 1'b0);
    m_va = m_va | 22'h1;
    step(2'b00, attr[7:0], 0, 0, 4'h0, 1'b0);
    step(2'b01, {2'($urandom), attr[13:8]}, 0, 0, 4'h0, 1'b0);
    m_va = pix_addr(attr, m_line);
    step(2'b10, 8'($urandom), 0, 0, 4'h0, 1'b0);
    step(2'b11, 8'($urandom), 0, 0, 4'h0, 1'b0);
    p = pix_val(attr, m_line, raw);
    step(2'b00, raw, 0, 0, 4'h0, 1'b0);
    if (rst_at_wr) begin
      rin    = 1'b1;
      clkcnt = 2'b01;
      @(posedge mck);
      #1;
      rin = 1'b0;
      check("rst_va", va, 0);
      check("rst_vram_a", vram_a, 0);
      check("rst_vram_do", vram_do, 0);
      check("rst_gry", vram_gry, 0);
      check("rst_we", vram_we, 0);
      check("rst_frame_done", frame_done, 0);
      m_col = 0; m_line = 0; frames_done = 0; pend = 0; fd_due = 0; m_va = '0;
      return;
    end
    step(2'b01, 8'($urandom), 1, base, p[7:4], attr[10]);
    pend      = 1;
    pend_addr = base + 1;
    pend_nib  = p[3:0];
    pend_gry  = attr[10];
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_line = (m_line + 1) % LINES;
    end
  endtask

  task automatic run_rand_char();
    logic [13:0] attr;
    logic [7:0]  raw;
    case ($urandom_range(0, 5))
      0:       attr = 14'h0800;
      1:       attr = 14'h0601;
      2:       attr = 14'h1001;
      3:       attr = 14'h3000;
      default: attr = 14'($urandom);
    endcase
    raw = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
    sbr = 11'($urandom);
    run_char(attr, raw, 0);
    chars_run++;
  endtask

  initial begin
    rin = 1'b1; lcdon = 1'b1; clkcnt = 2'b00; cdi = 8'h00;
    pb0 = 13'($urandom); pb1 = 10'($urandom); pb2 = 9'($urandom); pb3 = 11'($urandom);
    sbr = 11'h010;
    m_col = 0; m_line = 0; frames_done = 0; pend = 0; fd_due = 0; chars_run = 0;
    pend_addr = 0; pend_nib = 4'h0; pend_gry = 1'b0; m_va = '0;

    repeat (3) begin
      clkcnt = 2'($urandom);
      cdi    = 8'($urandom);
      @(posedge mck);
      #1;
    end
    check("reset_va", va, 0);
    check("reset_vram_a", vram_a, 0);
    check("reset_vram_do", vram_do, 0);
    check("reset_gry", vram_gry, 0);
    check("reset_we", vram_we, 0);
    check("reset_frame_done", frame_done, 0);
    rin = 1'b0;

    run_char(14'h0034, 8'hA5, 0);
    run_char(14'h1001, 8'h0F, 0);
    run_char(14'h3000, 8'hFF, 0);
    chars_run = 3;
    for (int i = 0; i < 2 * COLS * LINES - 3; i++) run_rand_char();
    for (int i = 0; i < 10; i++) run_rand_char();

    // Drop display enable mid-frame, then raise it away from the address slot.
    lcdon = 1'b0;
    step(2'b10, 8'($urandom), 0, 0, 4'h0, 1'b0);
    pend = 0; m_col = 0; m_line = 0;
    step(2'b11, 8'($urandom), 0, 0, 4'h0, 1'b0);
    lcdon = 1'b1;
    step(2'b00, 8'($urandom), 0, 0, 4'h0, 1'b0);
    step(2'b01, 8'($urandom), 0, 0, 4'h0, 1'b0);

    for (int i = 0; i < 3 * COLS * LINES; i++) run_rand_char();
    for (int i = 0; i < 5; i++) run_rand_char();
    run_char(14'h0601, 8'h3C, 1);
    for (int i = 0; i < 40; i++) run_rand_char();

    m_va = attr_addr(m_col, m_line);
    step(2'b10, 8'($urandom), pend, pend_addr, pend_nib, pend_gry);
    pend = 0;
    step(2'b11, 8'($urandom), 0, 0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
